// File: rtl/swervolf_rdarb_pkg.sv
// Shared types and constants for the SweRVolf two-master AXI4 read arbiter.
// The owner encoding doubles as the MSB of the slave-side read ID.
package swervolf_rdarb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } rdarb_state_e;

   localparam logic OWNER_LSU = 1'b0;
   localparam logic OWNER_IFU = 1'b1;

endpackage

// File: rtl/swervolf_rdarb_rr2.sv
// Two-way combinational arbiter. Returns a one-hot grant for req[1:0].
// In round-robin mode the requester not granted last wins a tie; in fixed
// mode the LSU (req[0]) always wins a tie. The last_grant register lives in
// the instantiating module.
module swervolf_rdarb_rr2
   import swervolf_rdarb_pkg::*;
(
   input  logic       fixed_prio,
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);

   // Pick a winner among the current requesters.
   always_comb begin
      // NOTE: assign a default before any branch so no path leaves grant
      // unassigned; a missing default in combinational logic infers a latch.
      grant = 2'b00;
      case (req)
         2'b01: grant = 2'b01;
         2'b10: grant = 2'b10;
         2'b11: begin
            if (fixed_prio || (last_grant == OWNER_IFU))
               grant = 2'b01;
            else
               grant = 2'b10;
         end
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/swervolf_axi_rd_arb.sv
// Two-master AXI4 read-channel arbiter: LSU (m0) and IFU (m1) share one
// read-only slave. One burst in flight at a time; the slave ID carries the
// owner in its MSB and R beats are routed combinationally to the owner.
// Build option: define SWERVOLF_RDARB_FIXED_PRIO_EN for fixed LSU priority
// on contention; otherwise contention is resolved round-robin.
module swervolf_axi_rd_arb
   import swervolf_rdarb_pkg::*;
#(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,

   // LSU (master 0)
   input  logic [ID_WIDTH-1:0]   m0_arid,
   input  logic [ADDR_WIDTH-1:0] m0_araddr,
   input  logic [7:0]            m0_arlen,
   input  logic [2:0]            m0_arsize,
   input  logic [1:0]            m0_arburst,
   input  logic                  m0_arvalid,
   output logic                  m0_arready,
   output logic [ID_WIDTH-1:0]   m0_rid,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic [1:0]            m0_rresp,
   output logic                  m0_rlast,
   output logic                  m0_rvalid,
   input  logic                  m0_rready,

   // IFU (master 1)
   input  logic [ID_WIDTH-1:0]   m1_arid,
   input  logic [ADDR_WIDTH-1:0] m1_araddr,
   input  logic [7:0]            m1_arlen,
   input  logic [2:0]            m1_arsize,
   input  logic [1:0]            m1_arburst,
   input  logic                  m1_arvalid,
   output logic                  m1_arready,
   output logic [ID_WIDTH-1:0]   m1_rid,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic [1:0]            m1_rresp,
   output logic                  m1_rlast,
   output logic                  m1_rvalid,
   input  logic                  m1_rready,

   // Shared slave
   output logic [ID_WIDTH:0]     s_arid,
   output logic [ADDR_WIDTH-1:0] s_araddr,
   output logic [7:0]            s_arlen,
   output logic [2:0]            s_arsize,
   output logic [1:0]            s_arburst,
   output logic                  s_arvalid,
   input  logic                  s_arready,
   input  logic [ID_WIDTH:0]     s_rid,
   input  logic [DATA_WIDTH-1:0] s_rdata,
   input  logic [1:0]            s_rresp,
   input  logic                  s_rlast,
   input  logic                  s_rvalid,
   output logic                  s_rready,

   output logic                  o_len_err
);

`ifdef SWERVOLF_RDARB_FIXED_PRIO_EN
   localparam logic FIXED_PRIO = 1'b1;
`else
   localparam logic FIXED_PRIO = 1'b0;
`endif

   rdarb_state_e state;
   logic         last_grant;
   logic [7:0]   beat_cnt;
   logic [1:0]   req;
   logic [1:0]   grant;
   logic         owner;
   logic         in_data;
   logic         r_hs;

   // The owner bit echoed back on s_rid is redundant: routing follows the
   // registered owner of the single outstanding burst.
   logic         rid_owner_unused;
   assign rid_owner_unused = s_rid[ID_WIDTH];

   // The captured s_arid MSB and s_arlen are the owner and expected length.
   assign owner   = s_arid[ID_WIDTH];
   assign in_data = (state == DATA);

   assign req = {m1_arvalid, m0_arvalid};

   swervolf_rdarb_rr2 u_arb (
      .fixed_prio (FIXED_PRIO),
      .req        (req),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // AR acceptance only while idle; the winner sees arready in the same cycle.
   assign m0_arready = (state == IDLE) & grant[0];
   assign m1_arready = (state == IDLE) & grant[1];

   // R path: zero-latency pass-through, valid/ready steered by the owner.
   assign m0_rvalid = in_data & s_rvalid & (owner == OWNER_LSU);
   assign m1_rvalid = in_data & s_rvalid & (owner == OWNER_IFU);
   assign s_rready  = in_data & ((owner == OWNER_IFU) ? m1_rready : m0_rready);
   assign r_hs      = s_rvalid & s_rready;

   assign m0_rid   = s_rid[ID_WIDTH-1:0];
   assign m0_rdata = s_rdata;
   assign m0_rresp = s_rresp;
   assign m0_rlast = s_rlast;
   assign m1_rid   = s_rid[ID_WIDTH-1:0];
   assign m1_rdata = s_rdata;
   assign m1_rresp = s_rresp;
   assign m1_rlast = s_rlast;

   // Burst FSM: grant capture, slave AR handshake, R beat counting and
   // length checking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= OWNER_IFU;
         beat_cnt   <= 8'd0;
         o_len_err  <= 1'b0;
         s_arvalid  <= 1'b0;
         s_arid     <= '0;
         s_araddr   <= '0;
         s_arlen    <= 8'd0;
         s_arsize   <= 3'd0;
         s_arburst  <= 2'd0;
      end else begin
         // NOTE: every register here uses non-blocking assignment so all
         // updates see the pre-edge values, independent of statement order.
         case (state)
            IDLE: begin
               if (grant[1]) begin
                  s_arid     <= {OWNER_IFU, m1_arid};
                  s_araddr   <= m1_araddr;
                  s_arlen    <= m1_arlen;
                  s_arsize   <= m1_arsize;
                  s_arburst  <= m1_arburst;
                  s_arvalid  <= 1'b1;
                  last_grant <= OWNER_IFU;
                  state      <= ADDR;
               end else if (grant[0]) begin
                  s_arid     <= {OWNER_LSU, m0_arid};
                  s_araddr   <= m0_araddr;
                  s_arlen    <= m0_arlen;
                  s_arsize   <= m0_arsize;
                  s_arburst  <= m0_arburst;
                  s_arvalid  <= 1'b1;
                  last_grant <= OWNER_LSU;
                  state      <= ADDR;
               end
            end
            ADDR: begin
               if (s_arready) begin
                  s_arvalid <= 1'b0;
                  beat_cnt  <= 8'd0;
                  state     <= DATA;
               end
            end
            DATA: begin
               if (r_hs) begin
                  beat_cnt <= beat_cnt + 8'd1;
                  // Error when rlast and "last expected beat" disagree:
                  // early rlast, or a non-last beat at the final count.
                  if (s_rlast != (beat_cnt == s_arlen))
                     o_len_err <= 1'b1;
                  if (s_rlast)
                     state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_swervolf_axi_rd_arb.sv
// Directed self-checking bench for swervolf_axi_rd_arb. Inputs are driven on
// the falling clock edge and outputs sampled 1 time unit later.
module tb_swervolf_axi_rd_arb;

`ifdef SWERVOLF_RDARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;

   logic [3:0]  m0_arid, m1_arid;
   logic [31:0] m0_araddr, m1_araddr;
   logic [7:0]  m0_arlen, m1_arlen;
   logic [2:0]  m0_arsize, m1_arsize;
   logic [1:0]  m0_arburst, m1_arburst;
   logic        m0_arvalid, m1_arvalid;
   logic        m0_arready, m1_arready;
   logic [3:0]  m0_rid, m1_rid;
   logic [63:0] m0_rdata, m1_rdata;
   logic [1:0]  m0_rresp, m1_rresp;
   logic        m0_rlast, m1_rlast;
   logic        m0_rvalid, m1_rvalid;
   logic        m0_rready, m1_rready;

   logic [4:0]  s_arid;
   logic [31:0] s_araddr;
   logic [7:0]  s_arlen;
   logic [2:0]  s_arsize;
   logic [1:0]  s_arburst;
   logic        s_arvalid, s_arready;
   logic [4:0]  s_rid;
   logic [63:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rlast, s_rvalid, s_rready;
   logic        o_len_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   swervolf_axi_rd_arb dut (
      .clk        (clk),        .rst        (rst),
      .m0_arid    (m0_arid),    .m0_araddr  (m0_araddr),  .m0_arlen   (m0_arlen),
      .m0_arsize  (m0_arsize),  .m0_arburst (m0_arburst), .m0_arvalid (m0_arvalid),
      .m0_arready (m0_arready), .m0_rid     (m0_rid),     .m0_rdata   (m0_rdata),
      .m0_rresp   (m0_rresp),   .m0_rlast   (m0_rlast),   .m0_rvalid  (m0_rvalid),
      .m0_rready  (m0_rready),
      .m1_arid    (m1_arid),    .m1_araddr  (m1_araddr),  .m1_arlen   (m1_arlen),
      .m1_arsize  (m1_arsize),  .m1_arburst (m1_arburst), .m1_arvalid (m1_arvalid),
      .m1_arready (m1_arready), .m1_rid     (m1_rid),     .m1_rdata   (m1_rdata),
      .m1_rresp   (m1_rresp),   .m1_rlast   (m1_rlast),   .m1_rvalid  (m1_rvalid),
      .m1_rready  (m1_rready),
      .s_arid     (s_arid),     .s_araddr   (s_araddr),   .s_arlen    (s_arlen),
      .s_arsize   (s_arsize),   .s_arburst  (s_arburst),  .s_arvalid  (s_arvalid),
      .s_arready  (s_arready),  .s_rid      (s_rid),      .s_rdata    (s_rdata),
      .s_rresp    (s_rresp),    .s_rlast    (s_rlast),    .s_rvalid   (s_rvalid),
      .s_rready   (s_rready),   .o_len_err  (o_len_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Raise one master's AR request at the next falling edge and check that it
   // alone sees arready in the same cycle.
   task automatic ar_issue(input logic own, input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input string tag);
      @(negedge clk);
      if (own) begin
         m1_arvalid = 1'b1; m1_arid = id; m1_araddr = addr; m1_arlen = len;
      end else begin
         m0_arvalid = 1'b1; m0_arid = id; m0_araddr = addr; m0_arlen = len;
      end
      #1;
      check({tag, "/arready"}, {m1_arready, m0_arready}, own ? 2'b10 : 2'b01);
      check({tag, "/s_arvalid_pre"}, s_arvalid, 1'b0);
   endtask

   // Drop requests, check the slave AR, accept it; returns at the first DATA cycle.
   task automatic ar_accept(input logic [4:0] exp_id, input logic [7:0] exp_len, input string tag);
      @(negedge clk);
      m0_arvalid = 1'b0; m1_arvalid = 1'b0;
      #1;
      check({tag, "/s_arvalid"}, s_arvalid, 1'b1);
      check({tag, "/s_arid"}, s_arid, exp_id);
      check({tag, "/s_arlen"}, s_arlen, exp_len);
      s_arready = 1'b1;
      @(negedge clk);
      s_arready = 1'b0;
   endtask

   // Called right after a grant: accept the AR and return one rlast beat.
   // Returns in the first IDLE cycle after rlast.
   task automatic serve_single(input logic own, input logic [4:0] exp_id, input logic drop,
                               input string tag);
      logic [63:0] d;
      @(negedge clk);
      if (drop) begin m0_arvalid = 1'b0; m1_arvalid = 1'b0; end
      #1;
      check({tag, "/s_arvalid"}, s_arvalid, 1'b1);
      check({tag, "/s_arid"}, s_arid, exp_id);
      check({tag, "/arready_busy"}, {m1_arready, m0_arready}, 2'b00);
      s_arready = 1'b1;
      @(negedge clk);
      s_arready = 1'b0;
      d = {32'hCAFE_0000, 27'd0, exp_id};
      s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = exp_id; s_rdata = d;
      m0_rready = 1'b1; m1_rready = 1'b1;
      #1;
      check({tag, "/rvalid"}, {m1_rvalid, m0_rvalid}, own ? 2'b10 : 2'b01);
      check({tag, "/s_rready"}, s_rready, 1'b1);
      check({tag, "/rdata"}, own ? m1_rdata : m0_rdata, d);
      check({tag, "/s_arvalid_done"}, s_arvalid, 1'b0);
      @(negedge clk);
      s_rvalid = 1'b0; s_rlast = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
   endtask

   initial begin
      logic exp_own;

      rst = 1'b1;
      m0_arid = 4'h1; m0_araddr = 32'h0000_0100; m0_arlen = 8'd0; m0_arsize = 3'd3; m0_arburst = 2'd1;
      m1_arid = 4'h2; m1_araddr = 32'h0000_0200; m1_arlen = 8'd0; m1_arsize = 3'd3; m1_arburst = 2'd1;
      m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
      s_arready = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = 2'b00; s_rlast = 1'b0; s_rvalid = 1'b0;

      // Reset state, including R gating with a stray s_rvalid.
      repeat (3) @(negedge clk);
      s_rvalid = 1'b1;
      #1;
      check("rst/s_arvalid", s_arvalid, 1'b0);
      check("rst/s_arid", s_arid, 5'h00);
      check("rst/s_araddr", s_araddr, 32'h0);
      check("rst/o_len_err", o_len_err, 1'b0);
      check("rst/rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
      check("rst/s_rready", s_rready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      s_rvalid = 1'b0;
      #1;
      check("idle/arready", {m1_arready, m0_arready}, 2'b00);

      // Contention from reset with both requests held: LSU, IFU, LSU, IFU
      // (LSU every time under fixed priority).
      @(negedge clk);
      m0_arvalid = 1'b1; m1_arvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_own = FIXED ? 1'b0 : i[0];
         #1;
         check($sformatf("rr%0d/arready", i), {m1_arready, m0_arready}, exp_own ? 2'b10 : 2'b01);
         serve_single(exp_own, exp_own ? 5'h12 : 5'h01, 1'b0, $sformatf("rr%0d", i));
      end
      m0_arvalid = 1'b0; m1_arvalid = 1'b0;

      // Single LSU read, len 0, id 3: minimum turnaround and R routing.
      m0_arsize = 3'd3; m0_arburst = 2'd1;
      ar_issue(1'b0, 4'h3, 32'h4000_0000, 8'd0, "t1");
      @(negedge clk);
      m0_arvalid = 1'b0;
      m0_araddr  = 32'hFFFF_FFFF;
      #1;
      check("t1/s_arvalid", s_arvalid, 1'b1);
      check("t1/s_arid", s_arid, 5'h03);
      check("t1/s_araddr", s_araddr, 32'h4000_0000);
      check("t1/s_arsize_burst", {s_arsize, s_arburst}, {3'd3, 2'd1});
      s_arready = 1'b1;
      @(negedge clk);
      s_arready = 1'b0;
      s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 5'h03; s_rresp = 2'b01;
      s_rdata = 64'h1122_3344_5566_7788; m0_rready = 1'b1; m1_rready = 1'b1;
      #1;
      check("t1/rvalid", {m1_rvalid, m0_rvalid}, 2'b01);
      check("t1/m0_rid", m0_rid, 4'h3);
      check("t1/m0_rdata", m0_rdata, 64'h1122_3344_5566_7788);
      check("t1/m0_rresp_rlast", {m0_rresp, m0_rlast}, {2'b01, 1'b1});
      @(negedge clk);
      s_rvalid = 1'b0; s_rlast = 1'b0; s_rresp = 2'b00;
      m1_arvalid = 1'b1; m1_arid = 4'h5; m1_araddr = 32'h0000_1000; m1_arlen = 8'd7;
      #1;
      check("t1/s_rready_idle", s_rready, 1'b0);
      check("t1/o_len_err", o_len_err, 1'b0);
      // Next grant in the first IDLE cycle after rlast.
      check("t3/m1_arready", {m1_arready, m0_arready}, 2'b10);

      // IFU len 7, slave AR stalled 5 cycles, LSU pending throughout.
      @(negedge clk);
      m1_arvalid = 1'b0; m1_araddr = 32'hDEAD_BEEF; m1_arlen = 8'd0;
      m0_arvalid = 1'b1; m0_arid = 4'h6; m0_araddr = 32'h0000_2000; m0_arlen = 8'd0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check($sformatf("t3/stall%0d/ar", i), {s_arvalid, s_arid, s_arlen}, {1'b1, 5'h15, 8'd7});
         check($sformatf("t3/stall%0d/addr", i), s_araddr, 32'h0000_1000);
         check($sformatf("t3/stall%0d/m0_arready", i), m0_arready, 1'b0);
         @(negedge clk);
      end
      s_arready = 1'b1;
      @(negedge clk);
      s_arready = 1'b0;
      // 12 cycles: beats 0-2, owner stalls rready for 4 cycles, beats 3-7.
      begin
         int k;
         logic stall;
         k = 0;
         for (int c = 0; c < 12; c++) begin
            stall = (c >= 3) && (c < 7);
            m1_rready = !stall; m0_rready = 1'b1;
            s_rvalid = 1'b1; s_rid = 5'h15; s_rdata = 64'hD000 + 64'(k); s_rlast = (k == 7);
            #1;
            check($sformatf("t3/c%0d/rvalid", c), {m1_rvalid, m0_rvalid}, 2'b10);
            check($sformatf("t3/c%0d/s_rready", c), s_rready, !stall);
            check($sformatf("t3/c%0d/m1_rdata", c), m1_rdata, 64'hD000 + 64'(k));
            check($sformatf("t3/c%0d/m0_arready", c), m0_arready, 1'b0);
            if (!stall) k++;
            @(negedge clk);
         end
      end
      s_rvalid = 1'b0; s_rlast = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
      #1;
      check("t3/o_len_err", o_len_err, 1'b0);
      check("t3/lsu_after_rlast", {m1_arready, m0_arready}, 2'b01);
      serve_single(1'b0, 5'h06, 1'b1, "t3/lsu");

      // LSU len 7 with rlast on the fourth beat: sticky length error.
      ar_issue(1'b0, 4'h7, 32'h0000_3000, 8'd7, "t4");
      ar_accept(5'h07, 8'd7, "t4");
      for (int k = 0; k < 4; k++) begin
         s_rvalid = 1'b1; s_rid = 5'h07; s_rdata = 64'hE0 + 64'(k); s_rlast = (k == 3);
         m0_rready = 1'b1;
         #1;
         check($sformatf("t4/b%0d/o_len_err", k), o_len_err, 1'b0);
         check($sformatf("t4/b%0d/m0_rvalid", k), m0_rvalid, 1'b1);
         @(negedge clk);
      end
      s_rvalid = 1'b0; s_rlast = 1'b0; m0_rready = 1'b0;
      #1;
      check("t4/o_len_err_set", o_len_err, 1'b1);
      m1_arvalid = 1'b1; m1_arid = 4'h9; m1_araddr = 32'h0000_9000; m1_arlen = 8'd0;
      #1;
      check("t4/next_grant", {m1_arready, m0_arready}, 2'b10);
      serve_single(1'b1, 5'h19, 1'b1, "t4/next");
      #1;
      check("t4/o_len_err_sticky", o_len_err, 1'b1);

      // Reset in the middle of a DATA phase.
      ar_issue(1'b0, 4'h2, 32'h0000_4000, 8'd3, "t6");
      ar_accept(5'h02, 8'd3, "t6");
      s_rvalid = 1'b1; s_rid = 5'h02; s_rlast = 1'b0; m0_rready = 1'b1;
      #1;
      check("t6/pre_rvalid", m0_rvalid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("t6/rst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
      check("t6/rst_ready", {s_rready, m1_arready, m0_arready}, 3'b000);
      check("t6/rst_arvalid", s_arvalid, 1'b0);
      check("t6/rst_len_err", o_len_err, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("t6/idle_rvalid", {m1_rvalid, m0_rvalid, s_rready}, 3'b000);
      s_rvalid = 1'b0; m0_rready = 1'b0;
      ar_issue(1'b0, 4'hA, 32'h0000_6000, 8'd0, "t6/post");
      serve_single(1'b0, 5'h0A, 1'b1, "t6/post");
      #1;
      check("t6/post_len_err", o_len_err, 1'b0);

      // Overrun: len 1 but three beats; the non-last beat at count 1 flags.
      ar_issue(1'b0, 4'h4, 32'h0000_5000, 8'd1, "t7");
      ar_accept(5'h04, 8'd1, "t7");
      for (int k = 0; k < 3; k++) begin
         s_rvalid = 1'b1; s_rid = 5'h04; s_rdata = 64'hF0 + 64'(k); s_rlast = (k == 2);
         m0_rready = 1'b1;
         #1;
         check($sformatf("t7/b%0d/o_len_err", k), o_len_err, (k == 2) ? 1'b1 : 1'b0);
         @(negedge clk);
      end
      s_rvalid = 1'b0; s_rlast = 1'b0; m0_rready = 1'b0;
      #1;
      check("t7/o_len_err_end", o_len_err, 1'b1);
      check("t7/idle_rready", s_rready, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
